// File: rtl/gf3_pkg.sv
// GF(3) element type, field arithmetic and the systemizer FSM state encoding.
// Elements are 2-bit codes 00=0, 01=1, 10=2; 11 never reaches the arithmetic.
package gf3_pkg;

   typedef logic [1:0] gf3_t;

   typedef enum logic [2:0] {
      IDLE,
      PIVOT,
      SEARCH,
      SWAP,
      NORM,
      ELIM,
      FINISH
   } state_t;

   function automatic gf3_t gf3_add(input gf3_t a, input gf3_t b);
      return gf3_t'((int'(a) + int'(b)) % 3);
   endfunction

   function automatic gf3_t gf3_sub(input gf3_t a, input gf3_t b);
      return gf3_t'((int'(a) + 3 - int'(b)) % 3);
   endfunction

   function automatic gf3_t gf3_mul(input gf3_t a, input gf3_t b);
      return gf3_t'((int'(a) * int'(b)) % 3);
   endfunction

endpackage

// File: rtl/gf3_row_op.sv
// Combinational BLOCK-wide GF(3) row update: diff = a - f*b (elimination), dbl = 2*a (normalise).
// Zero latency, no flow control.
module gf3_row_op
   import gf3_pkg::*;
#(
   parameter int BLOCK = 4
) (
   input  logic [2*BLOCK-1:0] a,
   input  logic [2*BLOCK-1:0] b,
   input  gf3_t               f,
   output logic [2*BLOCK-1:0] diff,
   output logic [2*BLOCK-1:0] dbl
);

   for (genvar j = 0; j < BLOCK; j++) begin : g_lane
      assign diff[2*j +: 2] = gf3_sub(a[2*j +: 2], gf3_mul(f, b[2*j +: 2]));
      assign dbl[2*j +: 2]  = gf3_add(a[2*j +: 2], a[2*j +: 2]);
   end

endmodule

// File: rtl/gf3_systemizer.sv
// In-place Gauss-Jordan reduction of a ROWS x COLS GF(3) matrix to [I | X]; host access only while idle, 1-cycle reads.
// Accesses while busy are dropped with an acc_err pulse; SYSTEMIZER_PIVOT_SEARCH_EN adds row-swap pivoting.
module gf3_systemizer
   import gf3_pkg::*;
#(
   parameter int ROWS  = 8,
   parameter int COLS  = 16,
   parameter int BLOCK = 4,
   localparam int AW   = $clog2(ROWS*COLS/BLOCK),
   localparam int DW   = 2*BLOCK
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          fail,
   output logic          success,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic          acc_err
);

   localparam int WORDS = ROWS*COLS/BLOCK;
   localparam int WPR   = COLS/BLOCK;
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int WW    = (WPR > 1) ? $clog2(WPR) : 1;

   if ((COLS % BLOCK) != 0 || COLS < ROWS) begin : g_bad_cfg
      $error("gf3_systemizer: COLS must be a multiple of BLOCK and not less than ROWS");
   end

   function automatic logic [AW-1:0] addr_of(input logic [RW-1:0] row, input int wi);
      return AW'(int'(row) * WPR + wi);
   endfunction

   function automatic gf3_t elem_of(input logic [DW-1:0] word, input logic [RW-1:0] col);
      return gf3_t'(word >> (2 * (int'(col) % BLOCK)));
   endfunction

   logic [DW-1:0] mem [WORDS];

   state_t        state, state_nxt;
   logic [RW-1:0] c, c_nxt, r, r_nxt;
   logic [WW-1:0] w, w_nxt;
   gf3_t          fac, fac_nxt;

   logic          we_a, we_b;
   logic [AW-1:0] addr_a, addr_b;
   logic [DW-1:0] data_a, data_b;
   logic          fin, fin_fail;

   logic [DW-1:0] word_c, word_r, op_a, op_diff, op_dbl;
   gf3_t          pivot, rc, f_eff;
   logic          last_w, last_r, last_c, start_acc;

   assign busy      = (state != IDLE) && (state != FINISH);
   assign start_acc = start && !busy;

   assign word_c = mem[addr_of(c, int'(w))];
   assign word_r = mem[addr_of(r, int'(w))];
   assign pivot  = elem_of(mem[addr_of(c, int'(c) / BLOCK)], c);
   assign rc     = elem_of(mem[addr_of(r, int'(c) / BLOCK)], c);
   assign last_w = (w == WW'(WPR - 1));
   assign last_r = (r == RW'(ROWS - 1));
   assign last_c = (c == RW'(ROWS - 1));

   // Writing the word that holds column c changes the live factor, so it is latched at w==0.
   assign f_eff = (w == '0) ? rc : fac;
   assign op_a  = (state == NORM) ? word_c : word_r;

   gf3_row_op #(.BLOCK(BLOCK)) u_row_op (
      .a    (op_a),
      .b    (word_c),
      .f    (f_eff),
      .diff (op_diff),
      .dbl  (op_dbl)
   );

   always_comb begin
      state_nxt = state;
      c_nxt     = c;
      r_nxt     = r;
      w_nxt     = w;
      fac_nxt   = fac;
      we_a      = 1'b0;
      we_b      = 1'b0;
      addr_a    = addr_of(c, int'(w));
      addr_b    = addr_of(r, int'(w));
      data_a    = word_r;
      data_b    = word_c;
      fin       = 1'b0;
      fin_fail  = 1'b0;
      case (state)
         IDLE, FINISH: begin
            state_nxt = IDLE;
            if (start) begin
               state_nxt = PIVOT;
               c_nxt     = '0;
            end
         end
         PIVOT: begin
            w_nxt = '0;
            if (pivot != 2'd0) begin
               state_nxt = NORM;
`ifdef SYSTEMIZER_PIVOT_SEARCH_EN
            end else if (!last_c) begin
               state_nxt = SEARCH;
               r_nxt     = c + 1'b1;
`endif
            end else begin
               state_nxt = FINISH;
               fin       = 1'b1;
               fin_fail  = 1'b1;
            end
         end
`ifdef SYSTEMIZER_PIVOT_SEARCH_EN
         SEARCH: begin
            if (rc != 2'd0) begin
               state_nxt = SWAP;
               w_nxt     = '0;
            end else if (last_r) begin
               state_nxt = FINISH;
               fin       = 1'b1;
               fin_fail  = 1'b1;
            end else begin
               r_nxt = r + 1'b1;
            end
         end
         SWAP: begin
            we_a = 1'b1;
            we_b = 1'b1;
            if (last_w) begin
               state_nxt = NORM;
               w_nxt     = '0;
            end else begin
               w_nxt = w + 1'b1;
            end
         end
`endif
         NORM: begin
            if (w == '0 && pivot == 2'd1) begin
               state_nxt = ELIM;
               r_nxt     = '0;
               w_nxt     = '0;
            end else begin
               we_a   = 1'b1;
               data_a = op_dbl;
               if (last_w) begin
                  state_nxt = ELIM;
                  r_nxt     = '0;
                  w_nxt     = '0;
               end else begin
                  w_nxt = w + 1'b1;
               end
            end
         end
         ELIM: begin
            if (r != c && f_eff != 2'd0) begin
               we_b    = 1'b1;
               data_b  = op_diff;
               fac_nxt = f_eff;
            end
            if (r == c || f_eff == 2'd0 || last_w) begin
               w_nxt = '0;
               if (!last_r) begin
                  r_nxt = r + 1'b1;
               end else if (last_c) begin
                  state_nxt = FINISH;
                  fin       = 1'b1;
               end else begin
                  state_nxt = PIVOT;
                  c_nxt     = c + 1'b1;
               end
            end else begin
               w_nxt = w + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         c     <= '0;
         r     <= '0;
         w     <= '0;
         fac   <= '0;
      end else begin
         state <= state_nxt;
         c     <= c_nxt;
         r     <= r_nxt;
         w     <= w_nxt;
         fac   <= fac_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done    <= 1'b0;
         fail    <= 1'b0;
         success <= 1'b0;
      end else if (start_acc) begin
         done    <= 1'b0;
         fail    <= 1'b0;
         success <= 1'b0;
      end else if (fin) begin
         done    <= 1'b1;
         fail    <= fin_fail;
         success <= !fin_fail;
      end
   end

   logic [DW-1:0]    wr_clean;
   logic [BLOCK-1:0] wr_bad;

   for (genvar j = 0; j < BLOCK; j++) begin : g_san
      assign wr_bad[j]          = &wr_data[2*j +: 2];
      assign wr_clean[2*j +: 2] = wr_bad[j] ? 2'b00 : wr_data[2*j +: 2];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '{default: '0};
      end else if (!busy) begin
         if (wr_en && int'(wr_addr) < WORDS) mem[wr_addr] <= wr_clean;
      end else begin
         if (we_a) mem[addr_a] <= data_a;
         if (we_b) mem[addr_b] <= data_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
         acc_err  <= 1'b0;
      end else begin
         rd_valid <= rd_en && !busy;
         rd_data  <= (rd_en && !busy && int'(rd_addr) < WORDS) ? mem[rd_addr] : '0;
         acc_err  <= (busy && (wr_en || rd_en)) || (!busy && wr_en && (|wr_bad));
      end
   end

endmodule

// File: tb/tb_gf3_systemizer.sv
// Bench for gf3_systemizer: a 2x4 instance for directed/table/random cases and a default 8x16 instance.
// Expectations follow SYSTEMIZER_PIVOT_SEARCH_EN when it is defined for the build.
module tb_gf3_systemizer;

   localparam int S_AW = 1;
   localparam int B_AW = 5;
`ifdef SYSTEMIZER_PIVOT_SEARCH_EN
   localparam bit SEARCH_ON = 1'b1;
`else
   localparam bit SEARCH_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic            s_start = 0, s_wr_en = 0, s_rd_en = 0;
   logic [S_AW-1:0] s_wr_addr = '0, s_rd_addr = '0;
   logic [7:0]      s_wr_data = '0, s_rd_data;
   logic            s_busy, s_done, s_fail, s_success, s_rd_valid, s_acc_err;

   logic            b_start = 0, b_wr_en = 0, b_rd_en = 0;
   logic [B_AW-1:0] b_wr_addr = '0, b_rd_addr = '0;
   logic [7:0]      b_wr_data = '0, b_rd_data;
   logic            b_busy, b_done, b_fail, b_success, b_rd_valid, b_acc_err;

   gf3_systemizer #(.ROWS(2), .COLS(4), .BLOCK(4)) u_small (
      .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
      .fail(s_fail), .success(s_success), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
      .wr_data(s_wr_data), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
      .rd_valid(s_rd_valid), .acc_err(s_acc_err)
   );

   gf3_systemizer u_big (
      .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
      .fail(b_fail), .success(b_success), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
      .wr_data(b_wr_data), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
      .rd_valid(b_rd_valid), .acc_err(b_acc_err)
   );

   int n_checks = 0;
   int n_errors = 0;
   int mdl [8][16];

   typedef struct {
      logic [7:0] row0;
      logic [7:0] row1;
      bit         ok;
      logic [7:0] exp0;
      logic [7:0] exp1;
      string      name;
   } vec_t;
   vec_t vecs [7];

   function automatic vec_t mkv(input logic [7:0] r0, input logic [7:0] r1, input bit ok,
                                input logic [7:0] e0, input logic [7:0] e1, input string nm);
      vec_t v;
      v.row0 = r0; v.row1 = r1; v.ok = ok; v.exp0 = e0; v.exp1 = e1; v.name = nm;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic busy_of(input bit big);
      return big ? b_busy : s_busy;
   endfunction

   task automatic wr(input bit big, input int addr, input logic [7:0] data);
      if (big) begin b_wr_en = 1; b_wr_addr = B_AW'(addr); b_wr_data = data; end
      else begin s_wr_en = 1; s_wr_addr = S_AW'(addr); s_wr_data = data; end
      @(posedge clk); #1;
      s_wr_en = 0; b_wr_en = 0;
   endtask

   task automatic check_word(input bit big, input int addr, input logic [7:0] exp, input string name);
      if (big) begin b_rd_en = 1; b_rd_addr = B_AW'(addr); end
      else begin s_rd_en = 1; s_rd_addr = S_AW'(addr); end
      @(posedge clk); #1;
      s_rd_en = 0; b_rd_en = 0;
      check({name, "_vld"}, big ? b_rd_valid : s_rd_valid, 1);
      check(name, big ? b_rd_data : s_rd_data, exp);
   endtask

   task automatic wait_idle(input bit big, input string name);
      int n = 0;
      while (busy_of(big) && n < 5000) begin @(posedge clk); #1; n++; end
      check({name, "_timeout"}, n >= 5000, 0);
   endtask

   task automatic run_dut(input bit big, input string name);
      if (big) b_start = 1; else s_start = 1;
      @(posedge clk); #1;
      b_start = 0; s_start = 0;
      check({name, "_busy"}, busy_of(big), 1);
      check({name, "_done_clr"}, big ? b_done : s_done, 0);
      wait_idle(big, name);
   endtask

   task automatic check_flags(input bit big, input bit ok, input string name);
      check({name, "_done"}, big ? b_done : s_done, 1);
      check({name, "_success"}, big ? b_success : s_success, ok);
      check({name, "_fail"}, big ? b_fail : s_fail, !ok);
   endtask

   function automatic logic [7:0] pack(input int r, input int w);
      logic [7:0] v = '0;
      for (int j = 0; j < 4; j++) v = v | (8'(mdl[r][w*4+j]) << (2*j));
      return v;
   endfunction

   task automatic load(input bit big, input int rows, input int cols);
      for (int r = 0; r < rows; r++)
         for (int w = 0; w < cols/4; w++) wr(big, r*(cols/4) + w, pack(r, w));
   endtask

   task automatic compare_mem(input bit big, input int rows, input int cols, input string tag);
      for (int r = 0; r < rows; r++)
         for (int w = 0; w < cols/4; w++)
            check_word(big, r*(cols/4) + w, pack(r, w), $sformatf("%s_r%0dw%0d", tag, r, w));
   endtask

   // Plain Gauss-Jordan over GF(3): first usable pivot at or below the diagonal; 1 and 2 are self-inverse.
   task automatic ref_run(input int rows, input int cols, output bit ok);
      ok = 1'b1;
      for (int c = 0; c < rows && ok; c++) begin
         int p, t, s, f;
         p = -1;
         if (mdl[c][c] != 0) p = c;
         else if (SEARCH_ON)
            for (int r = c + 1; r < rows; r++) if (p < 0 && mdl[r][c] != 0) p = r;
         if (p < 0) begin
            ok = 1'b0;
         end else begin
            for (int j = 0; j < cols; j++) begin
               t = mdl[c][j]; mdl[c][j] = mdl[p][j]; mdl[p][j] = t;
            end
            s = mdl[c][c];
            for (int j = 0; j < cols; j++) mdl[c][j] = (mdl[c][j] * s) % 3;
            for (int r = 0; r < rows; r++) begin
               if (r != c) begin
                  f = mdl[r][c];
                  for (int j = 0; j < cols; j++) mdl[r][j] = ((mdl[r][j] - f*mdl[c][j]) % 3 + 3) % 3;
               end
            end
         end
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bit ok;

      vecs[0] = mkv(8'h46, 8'h15, 1'b1, 8'h61, 8'hA4, "solve");
      vecs[1] = mkv(8'h04, 8'h01, SEARCH_ON, SEARCH_ON ? 8'h01 : 8'h04, SEARCH_ON ? 8'h04 : 8'h01, "swap");
      vecs[2] = mkv(8'h05, 8'h0A, 1'b0, 8'h05, 8'h00, "dependent");
      vecs[3] = mkv(8'h01, 8'h04, 1'b1, 8'h01, 8'h04, "identity");
      vecs[4] = mkv(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, "zero");
      vecs[5] = mkv(8'h02, 8'h08, 1'b1, 8'h01, 8'h04, "scale");
      vecs[6] = mkv(8'h04, 8'h04, 1'b0, 8'h04, 8'h04, "nopivot");

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", s_busy, 0);
      check("rst_done", s_done, 0);
      check("rst_fail", s_fail, 0);
      check("rst_success", s_success, 0);
      check("rst_rd_valid", s_rd_valid, 0);
      check("rst_rd_data", s_rd_data, 0);
      check("rst_acc_err", s_acc_err, 0);
      check("rst_big_busy", b_busy, 0);
      check("rst_big_done", b_done, 0);
      rst_n = 1;
      @(posedge clk); #1;
      check_word(0, 0, 8'h00, "rst_mem0");
      check_word(0, 1, 8'h00, "rst_mem1");

      for (int i = 0; i < 7; i++) begin
         wr(0, 0, vecs[i].row0);
         check({vecs[i].name, "_wr_err"}, s_acc_err, 0);
         wr(0, 1, vecs[i].row1);
         run_dut(0, vecs[i].name);
         check_flags(0, vecs[i].ok, vecs[i].name);
         check_word(0, 0, vecs[i].exp0, {vecs[i].name, "_w0"});
         check_word(0, 1, vecs[i].exp1, {vecs[i].name, "_w1"});
         check({vecs[i].name, "_sticky"}, s_done, 1);
      end

      wr(0, 0, 8'hFF);
      check("illegal_ff_err", s_acc_err, 1);
      @(posedge clk); #1;
      check("illegal_err_pulse", s_acc_err, 0);
      check_word(0, 0, 8'h00, "illegal_ff_mem");
      @(posedge clk); #1;
      check("idle_rd_valid", s_rd_valid, 0);
      check("idle_rd_data", s_rd_data, 0);
      wr(0, 1, 8'h3B);
      check("illegal_mix_err", s_acc_err, 1);
      check_word(0, 1, 8'h08, "illegal_mix_mem");

      wr(0, 0, 8'h46);
      wr(0, 1, 8'h15);
      s_start = 1;
      @(posedge clk); #1;
      s_start = 0;
      s_wr_en = 1; s_wr_addr = 0; s_wr_data = 8'h00;
      s_rd_en = 1; s_rd_addr = 1;
      @(posedge clk); #1;
      s_wr_en = 0; s_rd_en = 0;
      check("busy_acc_err", s_acc_err, 1);
      check("busy_rd_valid", s_rd_valid, 0);
      check("busy_rd_data", s_rd_data, 0);
      @(posedge clk); #1;
      check("busy_err_pulse", s_acc_err, 0);
      wait_idle(0, "busy_access");
      check_flags(0, 1'b1, "busy_access");
      check_word(0, 0, 8'h61, "busy_access_w0");
      check_word(0, 1, 8'hA4, "busy_access_w1");

      wr(0, 0, 8'h46);
      wr(0, 1, 8'h15);
      s_start = 1;
      @(posedge clk); #1;
      s_start = 0;
      repeat (2) @(posedge clk);
      #1;
      check("midrun_busy", s_busy, 1);
      rst_n = 0;
      #1;
      check("abort_busy", s_busy, 0);
      check("abort_done", s_done, 0);
      check("abort_fail", s_fail, 0);
      check("abort_success", s_success, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      @(posedge clk); #1;
      check_word(0, 0, 8'h00, "abort_mem0");
      check_word(0, 1, 8'h00, "abort_mem1");
      wr(0, 0, 8'h46);
      wr(0, 1, 8'h15);
      run_dut(0, "rerun");
      check_flags(0, 1'b1, "rerun");
      check_word(0, 0, 8'h61, "rerun_w0");
      check_word(0, 1, 8'hA4, "rerun_w1");

      for (int r = 0; r < 8; r++)
         for (int j = 0; j < 16; j++)
            mdl[r][j] = (j < 8) ? int'(r == j) : int'($urandom_range(0, 2));
      load(1, 8, 16);
      run_dut(1, "big_ident");
      check_flags(1, 1'b1, "big_ident");
      compare_mem(1, 8, 16, "big_ident");

      for (int t = 0; t < 30; t++) begin
         for (int r = 0; r < 2; r++)
            for (int j = 0; j < 4; j++) mdl[r][j] = int'($urandom_range(0, 2));
         load(0, 2, 4);
         ref_run(2, 4, ok);
         run_dut(0, $sformatf("rnd%0d", t));
         check_flags(0, ok, $sformatf("rnd%0d", t));
         compare_mem(0, 2, 4, $sformatf("rnd%0d", t));
      end

      for (int t = 0; t < 6; t++) begin
         for (int r = 0; r < 8; r++)
            for (int j = 0; j < 16; j++) mdl[r][j] = int'($urandom_range(0, 2));
         load(1, 8, 16);
         ref_run(8, 16, ok);
         run_dut(1, $sformatf("bigrnd%0d", t));
         check_flags(1, ok, $sformatf("bigrnd%0d", t));
         compare_mem(1, 8, 16, $sformatf("bigrnd%0d", t));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
